// File: rtl/vending_machine_credit.sv
// vending_machine_credit: parametrised coin-credit vending controller.
// Accumulates credit from three coin codes and vends once credit reaches PRICE.
// Any excess credit is paid back as one change_coin pulse per COIN1_VAL unit.
// A cancel request refunds all collected credit in the same way.
// Optional macro STOCK_COUNT_EN adds an item stock counter and sold_out gating.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_COLLECT | accepting coins and cancel requests
//   ST_VEND    | vend pulse for one cycle; PRICE is taken from the credit
//   ST_CHANGE  | one change_coin pulse per cycle until the credit is zero
module vending_machine_credit #(
   parameter int CREDIT_W   = 8,
   parameter int PRICE      = 15,
   parameter int COIN1_VAL  = 5,
   parameter int COIN2_VAL  = 10,
   parameter int COIN3_VAL  = 25,
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_in,
   input  logic                cancel,
   output logic                coin_ack,
   output logic                vend,
   output logic                change_coin,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic                sold_out
);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_VEND    = 2'd1,
      ST_CHANGE  = 2'd2
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] COIN1_C = CREDIT_W'(COIN1_VAL);
   localparam logic [CREDIT_W-1:0] COIN2_C = CREDIT_W'(COIN2_VAL);
   localparam logic [CREDIT_W-1:0] COIN3_C = CREDIT_W'(COIN3_VAL);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                coin_ack_q, coin_ack_d;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] credit_sum;
   logic [CREDIT_W-1:0] credit_rem;

`ifdef STOCK_COUNT_EN
   logic [STOCK_W-1:0] stock_q, stock_d;

   // One item leaves stock on every vend cycle; the guard keeps an empty counter from wrapping.
   always_comb begin
      stock_d = stock_q;
      if (state_q == ST_VEND && stock_q != '0) begin
         stock_d = stock_q - STOCK_W'(1);
      end
   end

   // Stock register, reloaded on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stock_q <= STOCK_W'(STOCK_INIT);
      end else begin
         stock_q <= stock_d;
      end
   end

   assign sold_out = (stock_q == '0);
`else
   assign sold_out = 1'b0;
`endif

   // Decode the coin code into its credit value.
   always_comb begin
      coin_val = '0;
      unique case (coin_in)
         2'b01:   coin_val = COIN1_C;
         2'b10:   coin_val = COIN2_C;
         2'b11:   coin_val = COIN3_C;
         default: coin_val = '0;
      endcase
   end

   // Next-state and next-credit logic; cancel beats any coin in the same cycle.
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      coin_ack_d = 1'b0;
      credit_sum = credit_q + coin_val;
      credit_rem = credit_q - PRICE_C;
      unique case (state_q)
         ST_COLLECT: begin
            if (cancel) begin
               if (credit_q != '0) begin
                  state_d = ST_CHANGE;
               end
            end else if (coin_in != 2'b00 && !sold_out) begin
               credit_d   = credit_sum;
               coin_ack_d = 1'b1;
               if (credit_sum >= PRICE_C) begin
                  state_d = ST_VEND;
               end
            end
         end
         ST_VEND: begin
            credit_d = credit_rem;
            state_d  = (credit_rem != '0) ? ST_CHANGE : ST_COLLECT;
         end
         ST_CHANGE: begin
            credit_d = credit_q - COIN1_C;
            if (credit_d == '0) begin
               state_d = ST_COLLECT;
            end
         end
         default: begin
            state_d  = ST_COLLECT;
            credit_d = '0;
         end
      endcase
   end

   // State, credit and acknowledge registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_COLLECT;
         credit_q   <= '0;
         coin_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         coin_ack_q <= coin_ack_d;
      end
   end

   assign coin_ack    = coin_ack_q;
   assign credit      = credit_q;
   assign vend        = (state_q == ST_VEND);
   assign change_coin = (state_q == ST_CHANGE);
   assign busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vending_machine_credit.sv
// Bench for vending_machine_credit: a directed vector table, hand-written
// reset/stock sequences, and random stimulus against an event-queue model.
module tb_vending_machine_credit;

   localparam int CREDIT_W  = 8;
   localparam int PRICE     = 15;
   localparam int COIN1_VAL = 5;
   localparam int COIN2_VAL = 10;
   localparam int COIN3_VAL = 25;
   localparam int STOCK_INIT = 8;
   localparam int STOCK_W   = 4;
`ifdef STOCK_COUNT_EN
   localparam bit STOCK_EN = 1'b1;
`else
   localparam bit STOCK_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          coin_in;
   logic                cancel;
   logic                coin_ack, vend, change_coin, busy, sold_out;
   logic [CREDIT_W-1:0] credit;
   logic [12:0]         dut_o;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vending_machine_credit #(
      .CREDIT_W(CREDIT_W), .PRICE(PRICE), .COIN1_VAL(COIN1_VAL),
      .COIN2_VAL(COIN2_VAL), .COIN3_VAL(COIN3_VAL),
      .STOCK_INIT(STOCK_INIT), .STOCK_W(STOCK_W)
   ) dut (
      .clk(clk), .rst(rst), .coin_in(coin_in), .cancel(cancel),
      .coin_ack(coin_ack), .vend(vend), .change_coin(change_coin),
      .busy(busy), .credit(credit), .sold_out(sold_out)
   );

   assign dut_o = {coin_ack, vend, change_coin, busy, sold_out, credit};

`ifdef STOCK_COUNT_EN
   logic [1:0]          s_coin;
   logic                s_cancel;
   logic                s_ack, s_vend, s_chg, s_busy, s_so;
   logic [CREDIT_W-1:0] s_credit;
   logic [12:0]         s_o;

   vending_machine_credit #(
      .CREDIT_W(CREDIT_W), .PRICE(PRICE), .COIN1_VAL(COIN1_VAL),
      .COIN2_VAL(COIN2_VAL), .COIN3_VAL(COIN3_VAL),
      .STOCK_INIT(1), .STOCK_W(STOCK_W)
   ) dut_s (
      .clk(clk), .rst(rst), .coin_in(s_coin), .cancel(s_cancel),
      .coin_ack(s_ack), .vend(s_vend), .change_coin(s_chg),
      .busy(s_busy), .credit(s_credit), .sold_out(s_so)
   );

   assign s_o = {s_ack, s_vend, s_chg, s_busy, s_so, s_credit};
`endif

   // ---------------- reference model ----------------
   // Output events still to be shown: 1 = vend cycle, 2 = change pulse.
   int m_q[$];
   int m_cur;
   int m_credit;
   bit m_ack;
   int m_stock;

   function automatic int coin_value(input logic [1:0] c);
      case (c)
         2'b01:   return COIN1_VAL;
         2'b10:   return COIN2_VAL;
         2'b11:   return COIN3_VAL;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset(input int stock_init);
      m_q.delete();
      m_cur    = 0;
      m_credit = 0;
      m_ack    = 1'b0;
      m_stock  = stock_init;
   endtask

   task automatic model_edge(input logic [1:0] c, input logic cx);
      m_ack = 1'b0;
      if (m_cur != 0) begin
         if (m_cur == 1) begin
            m_credit -= PRICE;
            if (m_stock > 0) m_stock--;
         end else begin
            m_credit -= COIN1_VAL;
         end
         m_cur = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end else begin
         if (cx) begin
            for (int k = 0; k < m_credit / COIN1_VAL; k++) m_q.push_back(2);
         end else if (c != 2'b00 && !(STOCK_EN && m_stock == 0)) begin
            m_credit += coin_value(c);
            m_ack = 1'b1;
            if (m_credit >= PRICE) begin
               m_q.push_back(1);
               for (int k = 0; k < (m_credit - PRICE) / COIN1_VAL; k++) m_q.push_back(2);
            end
         end
         m_cur = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end
   endtask

   function automatic logic [12:0] model_out();
      logic [7:0] cr;
      cr = 8'(m_credit);
      return {m_ack, m_cur == 1, m_cur == 2, m_cur != 0, STOCK_EN && m_stock == 0, cr};
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ack,vend,chg,busy,sold_out=%b credit=%0d, expected %b credit=%0d",
                  nm, act[12:8], act[7:0], exp[12:8], exp[7:0]);
      end
   endtask

   task automatic step(input logic [1:0] c, input logic cx);
      coin_in = c;
      cancel  = cx;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0] coin;
      logic       cx;
      logic       ack, vnd, chg, bsy;
      int         cr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] c, input logic cx, input logic a,
                               input logic v, input logic g, input logic b, input int cr);
      vec_t r;
      r.coin = c; r.cx = cx; r.ack = a; r.vnd = v; r.chg = g; r.bsy = b; r.cr = cr;
      return r;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] exp;
      logic [7:0]  cr8;
      logic [1:0]  rc;
      logic        rx;

      // three 5s, exact price, no change
      tbl.push_back(mk(2'd1, 0, 1, 0, 0, 0, 5));
      tbl.push_back(mk(2'd1, 0, 1, 0, 0, 0, 10));
      tbl.push_back(mk(2'd1, 0, 1, 1, 0, 1, 15));
      tbl.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0));
      // 10 + 25: vend then four change pulses
      tbl.push_back(mk(2'd2, 0, 1, 0, 0, 0, 10));
      tbl.push_back(mk(2'd3, 0, 1, 1, 0, 1, 35));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 20));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 15));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 10));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 5));
      tbl.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0));
      // cancel wins over a coin in the same cycle
      tbl.push_back(mk(2'd1, 0, 1, 0, 0, 0, 5));
      tbl.push_back(mk(2'd2, 1, 0, 0, 1, 1, 5));
      tbl.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0));
      // cancel with no credit: nothing, coin ignored
      tbl.push_back(mk(2'd1, 1, 0, 0, 0, 0, 0));
      // coins held during VEND/CHANGE are ignored
      tbl.push_back(mk(2'd2, 0, 1, 0, 0, 0, 10));
      tbl.push_back(mk(2'd3, 0, 1, 1, 0, 1, 35));
      tbl.push_back(mk(2'd3, 0, 0, 0, 1, 1, 20));
      tbl.push_back(mk(2'd3, 0, 0, 0, 1, 1, 15));
      tbl.push_back(mk(2'd3, 1, 0, 0, 1, 1, 10));
      tbl.push_back(mk(2'd3, 0, 0, 0, 1, 1, 5));
      tbl.push_back(mk(2'd3, 0, 0, 0, 0, 0, 0));
      // first COLLECT cycle after change accepts a coin
      tbl.push_back(mk(2'd3, 0, 1, 1, 0, 1, 25));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 10));
      tbl.push_back(mk(2'd0, 0, 0, 0, 1, 1, 5));
      tbl.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0));

      rst = 1'b1; coin_in = 2'b00; cancel = 1'b0;
`ifdef STOCK_COUNT_EN
      s_coin = 2'b00; s_cancel = 1'b0;
`endif
      #7;
      chk("reset_state", dut_o, 13'd0);
      #5;
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].coin, tbl[i].cx);
         cr8 = 8'(tbl[i].cr);
         exp = {tbl[i].ack, tbl[i].vnd, tbl[i].chg, tbl[i].bsy, 1'b0, cr8};
         chk($sformatf("table_row_%0d", i), dut_o, exp);
      end

      // asynchronous reset while paying change
      step(2'd3, 0);
      chk("async_pre_vend", dut_o, {5'b11010, 8'd25});
      step(2'd0, 0);
      chk("async_pre_change", dut_o, {5'b00110, 8'd10});
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset_immediate", dut_o, 13'd0);
      #2;
      rst = 1'b0;
      step(2'd1, 0);
      chk("after_async_reset_coin", dut_o, {5'b10000, 8'd5});

      // random stimulus against the event-queue model
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset(STOCK_INIT);
      chk("random_reset", dut_o, model_out());
      for (int i = 0; i < 3000; i++) begin
         rc = 2'($urandom_range(0, 3));
         rx = ($urandom_range(0, 9) == 0);
         step(rc, rx);
         model_edge(rc, rx);
         chk($sformatf("random_%0d", i), dut_o, model_out());
      end
      step(2'd0, 0);

`ifdef STOCK_COUNT_EN
      // stock of one: sell it, then coins are refused
      coin_in = 2'b00; cancel = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      chk("stock_reset", s_o, 13'd0);
      s_coin = 2'd2; @(posedge clk); #1;
      chk("stock_coin10", s_o, {5'b10000, 8'd10});
      s_coin = 2'd1; @(posedge clk); #1;
      chk("stock_vend", s_o, {5'b11010, 8'd15});
      s_coin = 2'd0; @(posedge clk); #1;
      chk("stock_sold_out", s_o, {5'b00001, 8'd0});
      s_coin = 2'd2; @(posedge clk); #1;
      chk("stock_coin_refused", s_o, {5'b00001, 8'd0});
      s_coin = 2'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/vending_machine_credit.md
Name: vending_machine_credit

Overview:
- Parametrised successor to the fixed two-coin vending FSM.
- Accumulates credit from three configurable coin denominations and vends when credit reaches a configurable PRICE.
- Returns any excess credit serially as unit-change pulses. Supports a cancel/refund request.
- Sits between the coin-validator front end and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 8, width of credit register. Constraint: PRICE-1+max(COINx_VAL) < 2**CREDIT_W.
- PRICE, 15, item price in currency units.
- COIN1_VAL, 5, value of coin code 2'b01. Also the change unit.
- COIN2_VAL, 10, value of coin code 2'b10. Must be a multiple of COIN1_VAL.
- COIN3_VAL, 25, value of coin code 2'b11. Must be a multiple of COIN1_VAL.
- STOCK_INIT, 8, initial item count. Used only with STOCK_COUNT_EN.
- STOCK_W, 4, width of stock counter. Used only with STOCK_COUNT_EN.
- PRICE must be a multiple of COIN1_VAL.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- coin_in  input  2  coin code per cycle: 00 none, 01/10/11 = COIN1/2/3
- cancel  input  1  level-sampled refund request
- coin_ack  output  1  registered; high one cycle after an accepted coin
- vend  output  1  high for exactly one cycle per sale
- change_coin  output  1  high one cycle per COIN1_VAL unit returned
- busy  output  1  high in VEND and CHANGE states
- credit  output  CREDIT_W  current credit register value
- sold_out  output  1  stock empty (tied 0 without STOCK_COUNT_EN)

Behaviour:
- Reset (async, any state): state=COLLECT, credit=0. coin_ack, vend, change_coin, busy all 0. Stock=STOCK_INIT.
- States: COLLECT, VEND, CHANGE. Outputs vend/change_coin/busy are decoded from the registered state. coin_ack and credit are registers.
- COLLECT, cancel=1 and credit>0: next=CHANGE. coin_in in the same cycle is ignored (cancel has priority; coin_ack=0).
- COLLECT, cancel=1 and credit==0: no action. Any coin in that cycle is also ignored.
- COLLECT, cancel=0, coin_in!=00: credit <= credit+value and coin_ack=1 next cycle. If the new credit >= PRICE, next=VEND; otherwise stay in COLLECT.
- Latency: the coin reaching PRICE is sampled at edge k. vend is high between edges k and k+1.
- VEND: vend=1 for one cycle; credit <= credit-PRICE. Next state is CHANGE if the remainder is >0, else COLLECT.
- CHANGE: change_coin=1 each cycle; credit <= credit-COIN1_VAL. When the post-decrement credit is 0, next=COLLECT.
  - Number of pulses = remaining credit / COIN1_VAL.
- VEND/CHANGE: coin_in and cancel are ignored entirely (coin_ack=0, no credit change). The upstream validator must hold coins while busy=1.
- Credit never exceeds PRICE-1+max coin (guaranteed by the parameter constraint). No saturation logic.
- Back-to-back: a coin presented on the first COLLECT cycle after CHANGE/VEND is accepted normally.
- Reset mid-CHANGE: remaining change is lost (credit cleared). This is acceptable by design.

Optional Feature:
- Macro STOCK_COUNT_EN.
- Defined:
  - Stock counter (STOCK_W) loads STOCK_INIT on reset and decrements on each VEND cycle.
  - sold_out = (stock==0), registered-state decode.
  - In COLLECT with sold_out=1, coins are not accepted: no coin_ack, credit unchanged.
  - cancel still refunds any existing credit.
- Undefined: no stock counter; sold_out tied 0; coins are always accepted in COLLECT.

Test Plan:
- Reset, then coin 01 on three consecutive cycles -> credit 5, 10, then VEND; vend pulses once, 0 change_coin pulses, credit ends 0, busy high 1 cycle.
- Coin 10 then 11 -> credit 35, vend one cycle, then 4 change_coin pulses over 4 cycles, credit 20→0, busy high 5 cycles, then back to COLLECT.
- Coin 01, then cancel=1 with coin_in=10 the same cycle -> coin ignored, 1 change_coin pulse, no vend, credit 0.
- Coin 11 sent during the CHANGE state -> coin_ack stays 0, credit follows only change decrements, pulse count unchanged.
- rst asserted asynchronously mid-CHANGE (between edges) -> change_coin, busy, credit drop to 0 immediately without waiting for clk; the next coin 01 gives credit 5.
- STOCK_COUNT_EN, STOCK_INIT=1: buy with coin 10+01 -> vend, sold_out=1; the next coin 10 is not acked and credit stays 0.
